// File: rtl/sync_fifo_param_pkg.sv
// Shared defaults and types for the single-clock parametrised FIFO.
package sync_fifo_param_pkg;
  localparam int DATASIZE = 8;
  localparam int ADDRSIZE = 4;
  typedef logic [DATASIZE-1:0] data_t;
endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bundle for sync_fifo_param; master drives requests, slave is the FIFO.
interface sync_fifo_param_if #(
  parameter int DATASIZE = sync_fifo_param_pkg::DATASIZE,
  parameter int ADDRSIZE = sync_fifo_param_pkg::ADDRSIZE
);
  logic                wen;
  logic [DATASIZE-1:0] wdata;
  logic                wack;
  logic                wfull;
  logic                wafull;
  logic                ren;
  logic [DATASIZE-1:0] rdata;
  logic                rack;
  logic                remty;
  logic                raemty;
  logic [ADDRSIZE:0]   count;
  logic                ovf;
  logic                udf;

  modport master (
    output wen, wdata, ren,
    input  wack, wfull, wafull, rdata, rack, remty, raemty, count, ovf, udf
  );

  modport slave (
    input  wen, wdata, ren,
    output wack, wfull, wafull, rdata, rack, remty, raemty, count, ovf, udf
  );
endinterface

// File: rtl/sync_fifo_param_mem.sv
// Storage array: one synchronous write port, one asynchronous read port. Contents survive reset.
module fifo_mem #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [ADDRSIZE-1:0] waddr_i,
  input  logic [DATASIZE-1:0] wdata_i,
  input  logic [ADDRSIZE-1:0] raddr_i,
  output logic [DATASIZE-1:0] rdata_o
);
  logic [DATASIZE-1:0] mem_q [2**ADDRSIZE];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered flags, occupancy count, sticky ovf/udf and optional FWFT read.
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int DATASIZE  = sync_fifo_param_pkg::DATASIZE,
  parameter int ADDRSIZE  = sync_fifo_param_pkg::ADDRSIZE,
  parameter int AFULL_TH  = 2**ADDRSIZE - 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic              wclk_i,
  input  logic              wrst_i,
  sync_fifo_param_if.slave  bus
);
  localparam logic [ADDRSIZE:0] DEPTH = (ADDRSIZE+1)'(2**ADDRSIZE);

  logic [ADDRSIZE:0]   wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic                wfull_q, wfull_d, remty_q, remty_d;
  logic                wafull_q, wafull_d, raemty_q, raemty_d;
  logic                ovf_q, ovf_d, udf_q, udf_d, rack_q, rack_d;
  logic [DATASIZE-1:0] rdata_q, rdata_d, mem_rdata;
  logic                wacc, racc;

  // Accept decisions use only registered flags, so no wen/ren-to-flag path exists.
  assign wacc = bus.wen && !wfull_q;
  assign racc = bus.ren && !remty_q;

  fifo_mem #(
    .DATASIZE (DATASIZE),
    .ADDRSIZE (ADDRSIZE)
  ) u_mem (
    .clk_i   (wclk_i),
    .we_i    (wacc),
    .waddr_i (wptr_q[ADDRSIZE-1:0]),
    .wdata_i (bus.wdata),
    .raddr_i (rptr_q[ADDRSIZE-1:0]),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    wptr_d   = wptr_q + {{ADDRSIZE{1'b0}}, wacc};
    rptr_d   = rptr_q + {{ADDRSIZE{1'b0}}, racc};
    count_d  = wptr_d - rptr_d;
    wfull_d  = (count_d == DEPTH);
    remty_d  = (count_d == '0);
    wafull_d = (int'(count_d) >= AFULL_TH);
    raemty_d = (int'(count_d) <= AEMPTY_TH);
    ovf_d    = ovf_q || (bus.wen && wfull_q);
    udf_d    = udf_q || (bus.ren && remty_q);
    rack_d   = (FWFT == 0) && racc;
    rdata_d  = racc ? mem_rdata : rdata_q;
  end

  always_ff @(posedge wclk_i) begin
    if (wrst_i) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      wfull_q  <= 1'b0;
      remty_q  <= 1'b1;
      wafull_q <= 1'b0;
      raemty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      rack_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      wfull_q  <= wfull_d;
      remty_q  <= remty_d;
      wafull_q <= wafull_d;
      raemty_q <= raemty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      rack_q   <= rack_d;
      rdata_q  <= rdata_d;
    end
  end

  // FWFT presents the head word directly; it reads as zero while empty so reset shows rdata=0.
  assign bus.rdata  = (FWFT != 0) ? (remty_q ? '0 : mem_rdata) : rdata_q;
  assign bus.rack   = (FWFT != 0) ? !remty_q : rack_q;
  assign bus.wack   = wacc;
  assign bus.wfull  = wfull_q;
  assign bus.wafull = wafull_q;
  assign bus.remty  = remty_q;
  assign bus.raemty = raemty_q;
  assign bus.count  = count_q;
  assign bus.ovf    = ovf_q;
  assign bus.udf    = udf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Drives a standard-read FIFO and an FWFT FIFO with custom thresholds from one stimulus stream.
module tb_sync_fifo_param;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wen = 1'b0;
  logic       ren = 1'b0;
  logic [7:0] wdata = 8'h00;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: a queue of stored words plus the sticky error bits and the registered read port.
  logic [7:0] q[$];
  logic       m_ovf = 1'b0, m_udf = 1'b0, m_rack0 = 1'b0;
  logic [7:0] m_rdata0 = 8'h00;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATASIZE(8), .ADDRSIZE(4)) if0 ();
  sync_fifo_param_if #(.DATASIZE(8), .ADDRSIZE(4)) if1 ();

  assign if0.wen = wen;  assign if0.wdata = wdata;  assign if0.ren = ren;
  assign if1.wen = wen;  assign if1.wdata = wdata;  assign if1.ren = ren;

  sync_fifo_param #(.DATASIZE(8), .ADDRSIZE(4), .FWFT(0)) dut0 (
    .wclk_i (clk), .wrst_i (rst), .bus (if0.slave)
  );

  sync_fifo_param #(.DATASIZE(8), .ADDRSIZE(4), .AFULL_TH(12), .AEMPTY_TH(3), .FWFT(1)) dut1 (
    .wclk_i (clk), .wrst_i (rst), .bus (if1.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_state();
    int n;
    n = q.size();
    check("count0",  32'(if0.count),  32'(n));
    check("count1",  32'(if1.count),  32'(n));
    check("wfull0",  32'(if0.wfull),  32'(n == 16));
    check("remty0",  32'(if0.remty),  32'(n == 0));
    check("wfull1",  32'(if1.wfull),  32'(n == 16));
    check("remty1",  32'(if1.remty),  32'(n == 0));
    check("wafull0", 32'(if0.wafull), 32'(n >= 14));
    check("raemty0", 32'(if0.raemty), 32'(n <= 2));
    check("wafull1", 32'(if1.wafull), 32'(n >= 12));
    check("raemty1", 32'(if1.raemty), 32'(n <= 3));
    check("ovf0",    32'(if0.ovf),    32'(m_ovf));
    check("udf0",    32'(if0.udf),    32'(m_udf));
    check("ovf1",    32'(if1.ovf),    32'(m_ovf));
    check("udf1",    32'(if1.udf),    32'(m_udf));
    check("rack0",   32'(if0.rack),   32'(m_rack0));
    check("rdata0",  32'(if0.rdata),  32'(m_rdata0));
    check("rack1",   32'(if1.rack),   32'(n != 0));
    check("rdata1",  32'(if1.rdata),  (n != 0) ? 32'(q[0]) : 32'h0);
  endtask

  // One clock: drive, check combinational wack, clock, update the model, check registered state.
  task automatic step(input bit w, input logic [7:0] d, input bit r, input bit rs);
    bit full, empty;
    wen = w; wdata = d; ren = r; rst = rs;
    #1;
    full  = (q.size() == 16);
    empty = (q.size() == 0);
    if (!rs) begin
      check("wack0", 32'(if0.wack), 32'(w && !full));
      check("wack1", 32'(if1.wack), 32'(w && !full));
    end
    @(posedge clk);
    if (rs) begin
      q.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_rack0 = 1'b0; m_rdata0 = 8'h00;
    end else begin
      m_rack0 = 1'b0;
      if (w && full)  m_ovf = 1'b1;
      if (r && empty) m_udf = 1'b1;
      if (r && !empty) begin
        m_rdata0 = q.pop_front();
        m_rack0  = 1'b1;
      end
      if (w && !full) q.push_back(d);
    end
    #1;
    check_state();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p_w, p_r;
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);

    // Fill to full and attempt one extra write, then drain past empty.
    for (int i = 0; i < 17; i++) step(1, 8'(i), 0, 0);
    for (int i = 0; i < 17; i++) step(0, 8'h00, 1, 0);

    // Steady state at count 8 with simultaneous push/pop; pointers wrap repeatedly.
    for (int i = 0; i < 8; i++)  step(1, 8'(8'h10 + i), 0, 0);
    for (int i = 0; i < 40; i++) step(1, 8'(8'h40 + i), 1, 0);

    // FWFT presentation of a single word with no read request, then pop.
    step(0, 8'h00, 0, 1);
    step(1, 8'hA5, 0, 0);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 1, 0);

    // Reset at count 9 discards contents; a new word still reads back.
    for (int i = 0; i < 9; i++) step(1, 8'(8'h80 + i), 0, 0);
    step(1, 8'hFF, 1, 1);
    step(1, 8'h3C, 0, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);

    // Full ramp up and down exercises every threshold boundary.
    for (int i = 0; i < 16; i++) step(1, 8'($urandom), 0, 0);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0);

    // Randomized phases biased toward filling, draining and balanced traffic.
    for (int ph = 0; ph < 12; ph++) begin
      case (ph % 3)
        0: begin p_w = 80; p_r = 25; end
        1: begin p_w = 25; p_r = 80; end
        default: begin p_w = 60; p_r = 60; end
      endcase
      for (int i = 0; i < 150; i++)
        step($urandom_range(0, 99) < p_w, 8'($urandom), $urandom_range(0, 99) < p_r,
             $urandom_range(0, 299) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
